riscv_uart_dump: RTL and testbench

UART memory-readback engine, the transmit-side counterpart of the UART programmer that loads instruction/data memory. On a start pulse it reads a run of 32-bit words through a synchronous memory read port and sends each word over `tx_o` as four 8N1 frames, least-significant byte first. It sits beside the programmer in the CPU top, sharing its 15-bit address convention: bit 14 = 1 selects data memory, 0 selects instruction memory. Host tools use it to verify a download or to dump the data segment after a run.

---
 rtl/riscv_uart_dump_if.sv | 24 ++
 rtl/riscv_uart_dump.sv | 234 +++++++++++++++++++++++
 tb/tb_riscv_uart_dump.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_uart_dump_if.sv
// riscv_uart_dump_if: request, memory read port and serial/status signals
// of the UART memory-readback engine. The engine connects through the
// slave modport; the host/memory side connects through master.
interface riscv_uart_dump_if;
  logic        start_i;
  logic [14:0] base_adr_i;
  logic [14:0] word_cnt_i;
  logic [14:0] mem_adr_o;
  logic        mem_ren_o;
  logic [31:0] mem_dat_i;
  logic        tx_o;
  logic        busy_o;
  logic        done_o;

  modport master (
    output start_i, base_adr_i, word_cnt_i, mem_dat_i,
    input  mem_adr_o, mem_ren_o, tx_o, busy_o, done_o
  );

  modport slave (
    input  start_i, base_adr_i, word_cnt_i, mem_dat_i,
    output mem_adr_o, mem_ren_o, tx_o, busy_o, done_o
  );
endinterface

// File: rtl/riscv_uart_dump.sv
// riscv_uart_dump: on a start request, reads a run of 32-bit words through a
// synchronous memory port and sends each one over tx_o as four 8N1 frames,
// least-significant byte first. Address bit 14 selects data memory.
// Optional feature: define RISCV_UART_DUMP_CHECKSUM_EN to append one frame
// carrying the XOR of every data byte sent in the run.
// All outputs are registered: the next-state logic also computes the value
// each output must take in the next state, and the register stage holds it.
module riscv_uart_dump #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic             clk,
  input  logic             rst,
  riscv_uart_dump_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CLK_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
`ifdef RISCV_UART_DUMP_CHECKSUM_EN
    , ST_CSUM = 3'd6
`endif
  } state_t;

  state_t           state_r,    state_s;
  logic [14:0]      adr_r,      adr_s;
  logic [14:0]      cnt_r,      cnt_s;
  logic [31:0]      shift_r,    shift_s;
  logic [1:0]       byte_idx_r, byte_idx_s;
  logic [2:0]       bit_idx_r,  bit_idx_s;
  logic [CNT_W-1:0] clk_cnt_r,  clk_cnt_s;
  logic [14:0]      mem_adr_r,  mem_adr_s;
  logic             mem_ren_r,  mem_ren_s;
  logic             tx_r,       tx_s;
  logic             busy_r,     busy_s;
  logic             done_r,     done_s;
  logic [7:0]       low_byte_s;
  logic             bit_end_s;

`ifdef RISCV_UART_DUMP_CHECKSUM_EN
  logic [7:0]       csum_r,       csum_s;
  logic             csum_phase_r, csum_phase_s;

  // XOR of the four bytes of a word, folded into the running checksum.
  function automatic logic [7:0] word_xor(input logic [31:0] w);
    word_xor = w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction
`endif

  // Next-state, datapath updates and next-cycle output values.
  always_comb begin
    state_s    = state_r;
    adr_s      = adr_r;
    cnt_s      = cnt_r;
    shift_s    = shift_r;
    byte_idx_s = byte_idx_r;
    bit_idx_s  = bit_idx_r;
    clk_cnt_s  = clk_cnt_r;
    done_s     = 1'b0;
    bit_end_s  = (clk_cnt_r == CLK_LAST);
`ifdef RISCV_UART_DUMP_CHECKSUM_EN
    csum_s       = csum_r;
    csum_phase_s = csum_phase_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (bus.start_i) begin
          adr_s      = bus.base_adr_i;
          cnt_s      = bus.word_cnt_i;
          byte_idx_s = 2'd0;
          bit_idx_s  = 3'd0;
          clk_cnt_s  = '0;
`ifdef RISCV_UART_DUMP_CHECKSUM_EN
          csum_s       = 8'd0;
          csum_phase_s = 1'b0;
`endif
          if (bus.word_cnt_i == 15'd0) begin
            done_s = 1'b1;
          end else begin
            state_s = ST_FETCH;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        // Memory answers the cycle after the strobe, i.e. now.
        shift_s   = bus.mem_dat_i;
        clk_cnt_s = '0;
        state_s   = ST_START;
`ifdef RISCV_UART_DUMP_CHECKSUM_EN
        csum_s = csum_r ^ word_xor(bus.mem_dat_i);
`endif
      end
      ST_START: begin
        if (bit_end_s) begin
          clk_cnt_s = '0;
          bit_idx_s = 3'd0;
          state_s   = ST_DATA;
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          clk_cnt_s = '0;
          if (bit_idx_r == 3'd7) begin
            bit_idx_s = 3'd0;
            state_s   = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          clk_cnt_s = '0;
`ifdef RISCV_UART_DUMP_CHECKSUM_EN
          if (csum_phase_r) begin
            csum_phase_s = 1'b0;
            done_s       = 1'b1;
            state_s      = ST_IDLE;
          end else
`endif
          if (byte_idx_r != 2'd3) begin
            shift_s    = {8'd0, shift_r[31:8]};
            byte_idx_s = byte_idx_r + 2'd1;
            state_s    = ST_START;
          end else if (cnt_r != 15'd1) begin
            // Wraps modulo 2^15; crossing into/out of data memory is allowed.
            adr_s      = adr_r + 15'd1;
            cnt_s      = cnt_r - 15'd1;
            byte_idx_s = 2'd0;
            state_s    = ST_FETCH;
          end else begin
`ifdef RISCV_UART_DUMP_CHECKSUM_EN
            state_s = ST_CSUM;
`else
            done_s  = 1'b1;
            state_s = ST_IDLE;
`endif
          end
        end else begin
          clk_cnt_s = clk_cnt_r + CNT_W'(1);
        end
      end
`ifdef RISCV_UART_DUMP_CHECKSUM_EN
      ST_CSUM: begin
        // One idle-high cycle to load the checksum byte as the next frame.
        shift_s      = {24'd0, csum_r};
        csum_phase_s = 1'b1;
        clk_cnt_s    = '0;
        state_s      = ST_START;
      end
`endif
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Output values for the state being entered.
    low_byte_s = shift_s[7:0];
    mem_ren_s  = (state_s == ST_FETCH);
    busy_s     = (state_s != ST_IDLE);
    if (state_s == ST_FETCH) begin
      mem_adr_s = adr_s;
    end else begin
      mem_adr_s = mem_adr_r;
    end
    case (state_s)
      ST_START: tx_s = 1'b0;
      ST_DATA:  tx_s = low_byte_s[bit_idx_s];
      default:  tx_s = 1'b1;
    endcase
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      adr_r      <= 15'd0;
      cnt_r      <= 15'd0;
      shift_r    <= 32'd0;
      byte_idx_r <= 2'd0;
      bit_idx_r  <= 3'd0;
      clk_cnt_r  <= '0;
      mem_adr_r  <= 15'd0;
      mem_ren_r  <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
`ifdef RISCV_UART_DUMP_CHECKSUM_EN
      csum_r       <= 8'd0;
      csum_phase_r <= 1'b0;
`endif
    end else begin
      state_r    <= state_s;
      adr_r      <= adr_s;
      cnt_r      <= cnt_s;
      shift_r    <= shift_s;
      byte_idx_r <= byte_idx_s;
      bit_idx_r  <= bit_idx_s;
      clk_cnt_r  <= clk_cnt_s;
      mem_adr_r  <= mem_adr_s;
      mem_ren_r  <= mem_ren_s;
      tx_r       <= tx_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
`ifdef RISCV_UART_DUMP_CHECKSUM_EN
      csum_r       <= csum_s;
      csum_phase_r <= csum_phase_s;
`endif
    end
  end

  assign bus.mem_adr_o = mem_adr_r;
  assign bus.mem_ren_o = mem_ren_r;
  assign bus.tx_o      = tx_r;
  assign bus.busy_o    = busy_r;
  assign bus.done_o    = done_r;

endmodule

// File: tb/tb_riscv_uart_dump.sv
// tb_riscv_uart_dump: scoreboard bench. Each start pushes the expected
// frames, memory reads and done timing; independent monitors decode tx_o,
// watch mem_ren_o and done_o, and compare against the queues.
`timescale 1ns/1ps
module tb_riscv_uart_dump;
  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;
  localparam int WORD  = 4 * FRAME + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_uart_dump_if bus ();

  riscv_uart_dump #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int epoch  = 0;

  logic [31:0] mem [0:32767];
  logic [7:0]  frame_data_q[$];
  int          frame_at_q[$];
  logic [14:0] adr_q[$];
  int          done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous memory: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_ren_o) bus.mem_dat_i <= mem[bus.mem_adr_o];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an event, required none", name);
  endtask

  // Expected traffic of one run accepted at edge E (ea = cycle E+1).
  task automatic push_run(input logic [14:0] base, input int n, input int ea);
    logic [7:0]  cs;
    logic [31:0] w;
    logic [14:0] a;
    cs = 8'd0;
    a  = base;
    for (int k = 0; k < n; k++) begin
      w = mem[a];
      adr_q.push_back(a);
      for (int b = 0; b < 4; b++) begin
        frame_data_q.push_back(w[8*b +: 8]);
        frame_at_q.push_back(ea + 2 + k * WORD + b * FRAME);
        cs = cs ^ w[8*b +: 8];
      end
      a = a + 15'd1;
    end
`ifdef RISCV_UART_DUMP_CHECKSUM_EN
    if (n > 0) begin
      frame_data_q.push_back(cs);
      frame_at_q.push_back(-1);
      done_q.push_back(-1);
    end else begin
      done_q.push_back(ea);
    end
`else
    done_q.push_back(ea + n * WORD);
`endif
  endtask

  task automatic start_run(input logic [14:0] base, input int n, output int ea);
    @(negedge clk);
    bus.base_adr_i = base;
    bus.word_cnt_i = 15'(n);
    bus.start_i    = 1'b1;
    ea = cyc + 1;
    push_run(base, n, ea);
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (bus.done_o !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_o pulse, required one within %0d cycles", budget);
    end
  endtask

  // UART receiver monitor.
  initial begin : uart_mon
    logic [7:0] rx;
    int st;
    int ep;
    forever begin
      @(negedge clk);
      if (!rst && bus.tx_o == 1'b0) begin
        st = cyc;
        ep = epoch;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx[i] = bus.tx_o;
        end
        repeat (CPB) @(negedge clk);
        if (ep == epoch) begin
          check("stop_bit", 32'(bus.tx_o), 32'd1);
          if (frame_data_q.size() == 0) begin
            fail_evt("frame_unexpected");
          end else begin
            check("frame_data", 32'(rx), 32'(frame_data_q.pop_front()));
            if (frame_at_q[0] >= 0) check("frame_start", 32'(st), 32'(frame_at_q[0]));
            void'(frame_at_q.pop_front());
          end
        end
      end
    end
  end

  // Memory read monitor.
  initial begin : mem_mon
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_ren_o) begin
        if (adr_q.size() == 0) fail_evt("read_unexpected");
        else check("read_adr", 32'(bus.mem_adr_o), 32'(adr_q.pop_front()));
      end
    end
  end

  // Completion monitor.
  initial begin : done_mon
    int e;
    forever begin
      @(negedge clk);
      if (!rst && bus.done_o) begin
        if (done_q.size() == 0) begin
          fail_evt("done_unexpected");
        end else begin
          e = done_q.pop_front();
          if (e >= 0) check("done_cycle", 32'(cyc), 32'(e));
          check("busy_at_done", 32'(bus.busy_o), 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int ea;
    int d;
    bus.start_i    = 1'b0;
    bus.base_adr_i = 15'd0;
    bus.word_cnt_i = 15'd0;
    mem[15'h4000] = 32'h12345678;
    mem[15'h7FFF] = 32'hA1B2C3D4;
    mem[15'h0000] = 32'h11223344;
    mem[15'h0010] = 32'hCAFEF00D;
    mem[15'h0020] = 32'h0BADBEEF;
    mem[15'h0100] = 32'h000000FF;
    mem[15'h0101] = 32'h0000000F;
    mem[15'h0200] = 32'h55AA33CC;

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_tx",      32'(bus.tx_o),      32'd1);
    check("rst_busy",    32'(bus.busy_o),    32'd0);
    check("rst_done",    32'(bus.done_o),    32'd0);
    check("rst_ren",     32'(bus.mem_ren_o), 32'd0);
    check("rst_mem_adr", 32'(bus.mem_adr_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // One word from data memory.
    start_run(15'h4000, 1, ea);
    check("busy_after_start", 32'(bus.busy_o), 32'd1);
    @(negedge clk);
    check("tx_high_in_wait", 32'(bus.tx_o), 32'd1);
    @(negedge clk);
    check("first_start_bit", 32'(bus.tx_o), 32'd0);
    wait_done(400);
    @(negedge clk);

    // Zero-length run.
    start_run(15'h1234, 0, ea);
    check("cnt0_busy", 32'(bus.busy_o), 32'd0);
    check("cnt0_tx",   32'(bus.tx_o),   32'd1);
    wait_done(5);
    @(negedge clk);
    check("cnt0_busy_after", 32'(bus.busy_o), 32'd0);
    repeat (3) @(negedge clk);

    // Address wrap from 0x7FFF to 0x0000.
    start_run(15'h7FFF, 2, ea);
    wait_done(800);
    repeat (3) @(negedge clk);

    // Reset during the second frame: only the first frame completes.
    start_run(15'h4000, 1, ea);
    while (cyc < ea + 58) @(negedge clk);
    rst = 1'b1;
    epoch++;
    frame_data_q.delete();
    frame_at_q.delete();
    adr_q.delete();
    done_q.delete();
    @(negedge clk);
    check("midrst_tx",   32'(bus.tx_o),   32'd1);
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    start_run(15'h0200, 1, ea);
    wait_done(400);
    repeat (3) @(negedge clk);

    // start_i held high: one run, then a new one on the done cycle with
    // the base address changed after the first acceptance.
    bus.base_adr_i = 15'h0010;
    bus.word_cnt_i = 15'd1;
    bus.start_i    = 1'b1;
    ea = cyc + 1;
    push_run(15'h0010, 1, ea);
    @(negedge clk);
    bus.base_adr_i = 15'h0020;
    wait_done(400);
    d = cyc;
    push_run(15'h0020, 1, d + 1);
    @(negedge clk);
    check("restart_on_done", 32'(bus.busy_o), 32'd1);
    bus.start_i = 1'b0;
    wait_done(400);
    repeat (3) @(negedge clk);

    // Two words for the checksum pattern (0xFF ^ 0x0F = 0xF0).
    start_run(15'h0100, 2, ea);
    wait_done(800);

    repeat (50) @(negedge clk);
    check("frames_left", 32'(frame_data_q.size()), 32'd0);
    check("reads_left",  32'(adr_q.size()),        32'd0);
    check("dones_left",  32'(done_q.size()),       32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
